// File: rtl/onchip_ram_pkg.sv
// Shared types and helpers for the pipelined Avalon on-chip RAM.
// Parity storage is enabled by defining ONCHIP_RAM_PARITY_EN.
package onchip_ram_pkg;

    typedef enum logic [1:0] {
        INIT,
        READY,
        DRAIN
    } state_t;

    localparam int MAX_READ_LATENCY = 2;

    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/onchip_ram_core.sv
// Byte-enabled single-port RAM array with registered read port.
// Parity bits per byte are stored when ONCHIP_RAM_PARITY_EN is defined.
module onchip_ram_core #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 40960,
    parameter int ADDR_W = 16
`ifdef ONCHIP_RAM_PARITY_EN
    ,
    parameter int PAR_W  = DATA_W / 8
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  re,
`ifdef ONCHIP_RAM_PARITY_EN
    input  logic [PAR_W-1:0]      wpar,
    output logic [PAR_W-1:0]      rpar,
`endif
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign in_range = 32'(addr) < 32'(DEPTH);
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    // Out-of-range reads return zero instead of aliasing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= in_range ? mem[idx] : '0;
        end
    end

`ifdef ONCHIP_RAM_PARITY_EN
    logic [PAR_W-1:0] pmem [DEPTH];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            for (int b = 0; b < PAR_W; b++) begin
                if (be[b]) pmem[idx][b] <= wpar[b];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpar <= '0;
        end else if (re) begin
            rpar <= in_range ? pmem[idx] : '0;
        end
    end
`endif

endmodule

// File: rtl/onchip_ram_avalon_pipelined.sv
// Avalon-MM pipelined slave wrapper: zero-fill FSM, handshake, read latency.
// Define ONCHIP_RAM_PARITY_EN to add per-byte parity and the parity_err port.
module onchip_ram_avalon_pipelined
    import onchip_ram_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 40960,
    parameter int ADDR_W         = 16,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                clken,
    input  logic                reset_req,
    output logic [DATA_W-1:0]   readdata,
    output logic                readdatavalid,
    output logic                waitrequest,
`ifdef ONCHIP_RAM_PARITY_EN
    output logic                parity_err,
`endif
    output logic                init_busy
);

    localparam int   NB   = DATA_W / 8;
    localparam logic CLR  = (CLEAR_ON_RESET != 0);
    localparam logic LAT2 = (READ_LATENCY == 2);

    state_t state, state_nx;

    logic [ADDR_W-1:0]           clr_addr;
    logic [MAX_READ_LATENCY-1:0] vpipe;
    logic [DATA_W-1:0]           rdata_d2;
    logic [DATA_W-1:0]           ram_q;
    logic [DATA_W-1:0]           ram_wdata;
    logic [ADDR_W-1:0]           ram_addr;
    logic [NB-1:0]               ram_be;
    logic                        ram_we;
    logic                        pipe_empty;
    logic                        fill;
    logic                        accept;
    logic                        rd_acc;

    assign pipe_empty  = ~|vpipe;
    assign fill        = CLR && (state == INIT) && clken;
    assign waitrequest = (state == READY) ? (~clken | reset_req) : 1'b1;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign rd_acc      = accept & read & ~write;
    assign init_busy   = CLR && (state == INIT);

    assign ram_we    = fill | (accept & write);
    assign ram_be    = fill ? '1 : byteenable;
    assign ram_addr  = fill ? clr_addr : address;
    assign ram_wdata = fill ? '0 : writedata;

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT: begin
                if (!CLR || clr_addr == ADDR_W'(DEPTH - 1)) state_nx = READY;
            end
            READY: begin
                if (reset_req) state_nx = DRAIN;
            end
            DRAIN: begin
                if (!reset_req && pipe_empty) state_nx = READY;
            end
            default: state_nx = INIT;
        endcase
    end

    // Stage 0 is the core's registered read; stage 1 only exists at latency 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            clr_addr <= '0;
            vpipe    <= '0;
            rdata_d2 <= '0;
        end else if (clken) begin
            state    <= state_nx;
            vpipe    <= {vpipe[0] & LAT2, rd_acc};
            rdata_d2 <= ram_q;
            if (fill) clr_addr <= clr_addr + ADDR_W'(1);
        end
    end

    assign readdatavalid = vpipe[READ_LATENCY-1];
    assign readdata      = LAT2 ? rdata_d2 : ram_q;

`ifdef ONCHIP_RAM_PARITY_EN
    logic [NB-1:0] ram_wpar;
    logic [NB-1:0] ram_qpar;
    logic [NB-1:0] byte_bad;
    logic          err_d2;

    always_comb begin
        ram_wpar = '0;
        byte_bad = '0;
        for (int b = 0; b < NB; b++) begin
            ram_wpar[b] = byte_parity(ram_wdata[8*b +: 8]);
            byte_bad[b] = byte_parity(ram_q[8*b +: 8]) ^ ram_qpar[b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_d2 <= 1'b0;
        end else if (clken) begin
            err_d2 <= |byte_bad;
        end
    end

    assign parity_err = readdatavalid & (LAT2 ? err_d2 : |byte_bad);
`endif

    onchip_ram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
`ifdef ONCHIP_RAM_PARITY_EN
        ,
        .PAR_W  (NB)
`endif
    ) u_core (
        .clk   (clk),
        .rst   (reset),
        .we    (ram_we),
        .be    (ram_be),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .re    (rd_acc),
`ifdef ONCHIP_RAM_PARITY_EN
        .wpar  (ram_wpar),
        .rpar  (ram_qpar),
`endif
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_onchip_ram_avalon_pipelined.sv
// Randomised bench for onchip_ram_avalon_pipelined against a behavioural model.
// Parity scenario is built only when ONCHIP_RAM_PARITY_EN is defined.
module tb_onchip_ram_avalon_pipelined;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int LAT   = 2;
    localparam int NB    = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic [NB-1:0] byteenable = '0;
    logic          chipselect = 1'b0;
    logic          read = 1'b0;
    logic          write = 1'b0;
    logic [DW-1:0] writedata = '0;
    logic          clken = 1'b1;
    logic          reset_req = 1'b0;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;
    logic          init_busy;
`ifdef ONCHIP_RAM_PARITY_EN
    logic          parity_err;
`endif

    always #5 clk = ~clk;

    onchip_ram_avalon_pipelined #(
        .DATA_W         (DW),
        .DEPTH          (DEPTH),
        .ADDR_W         (AW),
        .READ_LATENCY   (LAT),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .byteenable    (byteenable),
        .chipselect    (chipselect),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .clken         (clken),
        .reset_req     (reset_req),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .waitrequest   (waitrequest),
`ifdef ONCHIP_RAM_PARITY_EN
        .parity_err    (parity_err),
`endif
        .init_busy     (init_busy)
    );

    // Model: memory image, expected responses keyed by enabled-edge count.
    typedef struct {
        logic [DW-1:0] data;
        int            due;
        logic          perr;
    } resp_t;

    resp_t         rq[$];
    logic [DW-1:0] mmem [DEPTH];
    logic [NB-1:0] bad  [DEPTH];
    int            ecount = 0;
    int            init_left = DEPTH;
    int            mstate = 0;
    int            vectors = 0;
    int            errors = 0;

    task automatic check_outputs();
        logic exp_v;
        while (rq.size() > 0 && rq[0].due < ecount) void'(rq.pop_front());
        exp_v = (rq.size() > 0) && (rq[0].due == ecount);
        vectors++;
        if (readdatavalid !== exp_v) begin
            errors++;
            $display("FAIL readdatavalid: got %b want %b t=%0t", readdatavalid, exp_v, $time);
        end
        if (exp_v) begin
            vectors++;
            if (readdata !== rq[0].data) begin
                errors++;
                $display("FAIL readdata: got %h want %h t=%0t", readdata, rq[0].data, $time);
            end
        end
`ifdef ONCHIP_RAM_PARITY_EN
        vectors++;
        if (parity_err !== (exp_v && rq[0].perr)) begin
            errors++;
            $display("FAIL parity_err: got %b want %b t=%0t", parity_err, exp_v && rq[0].perr, $time);
        end
`endif
        vectors++;
        if (init_busy !== (mstate == 0)) begin
            errors++;
            $display("FAIL init_busy: got %b want %b t=%0t", init_busy, mstate == 0, $time);
        end
    endtask

    // One clock: starts and ends on a falling edge.
    task automatic step(input logic cs, input logic rd, input logic wr,
                        input logic [AW-1:0] a, input logic [NB-1:0] be,
                        input logic [DW-1:0] wd, input logic ce, input logic rr);
        logic  exp_wait;
        resp_t r;
        check_outputs();
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = a;
        byteenable = be;
        writedata  = wd;
        clken      = ce;
        reset_req  = rr;
        #1;
        exp_wait = !(mstate == 1 && ce && !rr);
        vectors++;
        if (waitrequest !== exp_wait) begin
            errors++;
            $display("FAIL waitrequest: got %b want %b t=%0t", waitrequest, exp_wait, $time);
        end
        if (ce) begin
            ecount++;
            if (mstate == 0) begin
                init_left--;
                if (init_left == 0) begin
                    mstate = 1;
                    for (int i = 0; i < DEPTH; i++) begin
                        mmem[i] = '0;
                        bad[i]  = '0;
                    end
                end
            end else if (mstate == 1) begin
                if (cs && wr && !rr) begin
                    if (a < DEPTH) begin
                        for (int b = 0; b < NB; b++) begin
                            if (be[b]) begin
                                mmem[a][8*b +: 8] = wd[8*b +: 8];
                                bad[a][b] = 1'b0;
                            end
                        end
                    end
                end else if (cs && rd && !rr) begin
                    r.data = (a < DEPTH) ? mmem[a] : '0;
                    r.perr = (a < DEPTH) ? |bad[a] : 1'b0;
                    r.due  = ecount + LAT - 1;
                    rq.push_back(r);
                end
                if (rr) mstate = 2;
            end else begin
                if (!rr && rq.size() == 0) mstate = 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0, '0, 1, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        step(1, 1, 0, a, '0, '0, 1, 0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [NB-1:0] be, input logic [DW-1:0] wd);
        step(1, 0, 1, a, be, wd, 1, 0);
    endtask

    task automatic do_reset(input logic chk);
        reset      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        clken      = 1'b1;
        reset_req  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (chk) begin
            vectors += 4;
            if (waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL reset waitrequest: got %b want 1", waitrequest);
            end
            if (readdatavalid !== 1'b0) begin
                errors++;
                $display("FAIL reset readdatavalid: got %b want 0", readdatavalid);
            end
            if (readdata !== '0) begin
                errors++;
                $display("FAIL reset readdata: got %h want 0", readdata);
            end
            if (init_busy !== 1'b1) begin
                errors++;
                $display("FAIL reset init_busy: got %b want 1", init_busy);
            end
        end
        rq.delete();
        mstate    = 0;
        init_left = DEPTH;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1);
    endtask

    task automatic test_init_fill();
        idle(DEPTH + 1);
        for (int i = 0; i < DEPTH; i++) do_read(AW'(i));
        idle(LAT + 1);
    endtask

    task automatic test_byteenable();
        do_write(5'd3, 4'b0101, 32'hDEADBEEF);
        do_read(5'd3);
        do_write(5'd7, 4'b0000, 32'hFFFFFFFF);
        do_read(5'd7);
        idle(LAT + 1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) do_write(AW'(i), 4'hF, 32'h10 + i);
        for (int i = 0; i < 4; i++) do_read(AW'(i));
        idle(LAT + 1);
    endtask

    task automatic test_rw_same();
        step(1, 1, 1, 5'd9, 4'hF, 32'hCAFEF00D, 1, 0);
        do_read(5'd9);
        idle(LAT + 1);
    endtask

    task automatic test_drain();
        do_read(5'd0);
        do_read(5'd1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 5'd2, '0, '0, 1, 1);
        idle(2);
        do_read(5'd2);
        idle(LAT + 1);
    endtask

    task automatic test_clken_stall();
        do_read(5'd2);
        for (int i = 0; i < 5; i++) step(1, 1, 0, 5'd3, '0, '0, 0, 0);
        idle(LAT + 1);
    endtask

    task automatic test_out_of_range();
        do_write(5'd20, 4'hF, 32'h55AA55AA);
        do_read(5'd20);
        do_read(5'd4);
        idle(LAT + 1);
    endtask

    task automatic test_reset_midflight();
        do_write(5'd1, 4'hF, 32'h01020304);
        do_read(5'd1);
        do_reset(1);
        idle(7);
        do_reset(0);
        idle(DEPTH + 1);
        do_read(5'd1);
        do_read(5'd3);
        idle(LAT + 1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0,
                 AW'($urandom_range(0, 31)),
                 NB'($urandom),
                 $urandom,
                 $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) == 0);
        end
        idle(LAT + 3);
    endtask

`ifdef ONCHIP_RAM_PARITY_EN
    task automatic test_parity();
        do_write(5'd5, 4'hF, 32'h12345678);
        do_write(5'd6, 4'hF, 32'h9ABCDEF0);
        dut.u_core.mem[5][16] = ~dut.u_core.mem[5][16];
        mmem[5][16] = ~mmem[5][16];
        bad[5][2]   = 1'b1;
        do_read(5'd5);
        do_read(5'd6);
        do_read(5'd21);
        idle(LAT + 1);
    endtask
`endif

    initial begin
        test_reset();
        test_init_fill();
        test_byteenable();
        test_back_to_back();
        test_rw_same();
        test_drain();
        test_clken_stall();
        test_out_of_range();
`ifdef ONCHIP_RAM_PARITY_EN
        test_parity();
`endif
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
